gpio_periph: RTL and testbench

//  Parametrised memory-mapped GPIO peripheral, successor to the fixed 8-bit output latch at 10'h50.

---
 rtl/gpio_periph.sv | 179 +++++++++++++++++
 tb/tb_gpio_periph.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_periph.sv
// ---------------------------------------------------------------------------
// gpio_periph
//   Memory-mapped GPIO peripheral on the CPU data-memory bus. It provides
//   WIDTH channels with an output latch, direction control, atomic
//   set/clear/toggle, a synchronised input view and edge-triggered interrupt
//   status with write-1-to-clear.
//
//   Register map (byte offset from BASE_ADDR, word aligned):
//     0x00 OUT   RW     0x10 DIR   RW
//     0x04 SET   W      0x14 IN    RO  (synchronised pins)
//     0x08 CLR   W      0x18 IEN   RW
//     0x0C TGL   W      0x1C STAT  RW1C
//   Write-only registers read as 0. Unaligned or out-of-window accesses
//   are ignored and read as 0.
//
// Ports
//   clk       system clock, all state on posedge
//   rst       asynchronous active-high reset
//   address   bus byte address (10 bits)
//   data_in   write data; bits above WIDTH-1 are ignored
//   write     write strobe
//   data_out  registered read data, zero-extended above WIDTH-1
//   gpio_in   asynchronous pin inputs
//   gpio_out  OUT register
//   gpio_oe   DIR register (1 = drive)
//   irq       |(STAT & IEN)
// ---------------------------------------------------------------------------
module gpio_periph #(
  parameter int               WIDTH     = 8,
  parameter logic [9:0]       BASE_ADDR = 10'h50,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       address,
  input  logic [31:0]      data_in,
  input  logic             write,
  output logic [31:0]      data_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [9:0] WIN_SIZE = 10'd32;

  // Word index inside the window (offset[4:2]).
  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_SET  = 3'd1;
  localparam logic [2:0] REG_CLR  = 3'd2;
  localparam logic [2:0] REG_TGL  = 3'd3;
  localparam logic [2:0] REG_DIR  = 3'd4;
  localparam logic [2:0] REG_IN   = 3'd5;
  localparam logic [2:0] REG_IEN  = 3'd6;
  localparam logic [2:0] REG_STAT = 3'd7;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       arm_q;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [9:0]       offset;
  logic             hit;
  logic [2:0]       reg_sel;
  logic             wr_hit;
  logic [WIDTH-1:0] wdata;

  // Subtracting the base and comparing against the window size covers both
  // the lower and upper window bounds with one compare.
  assign offset  = address - BASE_ADDR;
  assign hit     = (offset < WIN_SIZE) && (offset[1:0] == 2'b00);
  assign reg_sel = offset[4:2];
  assign wr_hit  = write && hit;
  assign wdata   = data_in[WIDTH-1:0];

  // Bits of data_in above WIDTH-1 are intentionally dropped.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  // -------------------------------------------------------------------------
  // OUT next-state: direct write plus atomic set/clear/toggle
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (wr_hit) begin
      case (reg_sel)
        REG_OUT: out_d = wdata;
        REG_SET: out_d = out_q | wdata;
        REG_CLR: out_d = out_q & ~wdata;
        REG_TGL: out_d = out_q ^ wdata;
        default: out_d = out_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Edge detection and interrupt status
  // -------------------------------------------------------------------------
  logic             armed;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] stat_d;

  // The arm counter hides the reset-release transient: pins already high
  // while in reset ripple through sync/prev within three cycles and must
  // not look like an edge.
  assign armed    = (arm_q == 2'd3);
  assign edge_det = armed ? (sync2_q ^ prev_q) : '0;
  assign stat_clr = (wr_hit && (reg_sel == REG_STAT)) ? wdata : '0;
  // A detected edge overrides a simultaneous W1C of the same bit so that
  // no event is lost.
  assign stat_d   = (stat_q & ~stat_clr) | edge_det;

  // -------------------------------------------------------------------------
  // Read mux (pre-write register values)
  // -------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (hit) begin
      case (reg_sel)
        REG_OUT:  rd_word[WIDTH-1:0] = out_q;
        REG_DIR:  rd_word[WIDTH-1:0] = dir_q;
        REG_IN:   rd_word[WIDTH-1:0] = sync2_q;
        REG_IEN:  rd_word[WIDTH-1:0] = ien_q;
        REG_STAT: rd_word[WIDTH-1:0] = stat_q;
        default:  rd_word = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= RESET_OUT;
      dir_q    <= '0;
      ien_q    <= '0;
      stat_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      arm_q    <= 2'd0;
      data_out <= '0;
    end else begin
      out_q    <= out_d;
      stat_q   <= stat_d;
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      data_out <= rd_word;
      if (!armed) begin
        arm_q <= arm_q + 2'd1;
      end
      if (wr_hit && (reg_sel == REG_DIR)) begin
        dir_q <= wdata;
      end
      if (wr_hit && (reg_sel == REG_IEN)) begin
        ien_q <= wdata;
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(stat_q & ien_q);

endmodule

// File: tb/tb_gpio_periph.sv
// ---------------------------------------------------------------------------
// tb_gpio_periph
//   Self-checking bench for gpio_periph (WIDTH=8, BASE_ADDR=10'h50,
//   RESET_OUT=8'h5A). Read expectations are queued when a read is issued
//   and compared when data_out is valid one cycle later.
// ---------------------------------------------------------------------------
module tb_gpio_periph;

  localparam int               W       = 8;
  localparam logic [9:0]       BASE    = 10'h50;
  localparam logic [W-1:0]     RST_OUT = 8'h5A;

  localparam logic [9:0] A_OUT  = BASE + 10'h00;
  localparam logic [9:0] A_SET  = BASE + 10'h04;
  localparam logic [9:0] A_CLR  = BASE + 10'h08;
  localparam logic [9:0] A_TGL  = BASE + 10'h0C;
  localparam logic [9:0] A_DIR  = BASE + 10'h10;
  localparam logic [9:0] A_IN   = BASE + 10'h14;
  localparam logic [9:0] A_IEN  = BASE + 10'h18;
  localparam logic [9:0] A_STAT = BASE + 10'h1C;
  localparam logic [9:0] A_IDLE = 10'h3FF;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    address;
  logic [31:0]   data_in;
  logic          write;
  logic [31:0]   data_out;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  gpio_periph #(
    .WIDTH    (W),
    .BASE_ADDR(BASE),
    .RESET_OUT(RST_OUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data_in (data_in),
    .write   (write),
    .data_out(data_out),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    write   = 1'b1;
    @(posedge clk);
    #1;
    write   = 1'b0;
    address = A_IDLE;
    data_in = '0;
  endtask

  task automatic bus_read(input string tag, input logic [9:0] a, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    address = a;
    write   = 1'b0;
    @(posedge clk);
    #1;
    address = A_IDLE;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, data_out, e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    address = A_IDLE;
    data_in = '0;
    write   = 1'b0;
    gpio_in = '0;
    cycles(3);

    // Reset values
    check_val("rst_out", 32'(gpio_out), 32'(RST_OUT));
    check_val("rst_oe",  32'(gpio_oe),  32'h0);
    check_val("rst_irq", 32'(irq),      32'h0);
    check_val("rst_rd",  data_out,      32'h0);
    rst = 1'b0;
    cycles(4);

    // Set / clear / toggle
    bus_write(A_OUT, 32'h0F);
    check_val("out_wr", 32'(gpio_out), 32'h0F);
    bus_write(A_SET, 32'h30);
    check_val("out_set", 32'(gpio_out), 32'h3F);
    bus_write(A_CLR, 32'h01);
    check_val("out_clr", 32'(gpio_out), 32'h3E);
    bus_write(A_TGL, 32'hFF);
    check_val("out_tgl", 32'(gpio_out), 32'hC1);
    bus_read("rd_set", A_SET, 32'h0);
    bus_read("rd_clr", A_CLR, 32'h0);
    bus_read("rd_tgl", A_TGL, 32'h0);
    bus_read("rd_out", A_OUT, 32'hC1);
    bus_write(A_DIR, 32'hA5);
    check_val("dir_oe", 32'(gpio_oe), 32'hA5);
    bus_read("rd_dir", A_DIR, 32'hA5);

    // Edge interrupt on bit 2: pin changes before edge k, STAT at k+2
    bus_write(A_IEN, 32'h04);
    bus_read("rd_ien", A_IEN, 32'h04);
    gpio_in[2] = 1'b1;
    cycles(1);
    check_val("irq_k", 32'(irq), 32'h0);
    cycles(1);
    check_val("irq_k1", 32'(irq), 32'h0);
    cycles(1);
    check_val("irq_k2", 32'(irq), 32'h1);
    bus_read("stat_set", A_STAT, 32'h04);
    bus_read("rd_in", A_IN, 32'h04);
    bus_write(A_STAT, 32'h04);
    check_val("irq_w1c", 32'(irq), 32'h0);
    bus_read("stat_w1c", A_STAT, 32'h00);

    // STAT records edges on non-enabled bits without raising irq
    gpio_in[5] = 1'b1;
    cycles(3);
    check_val("irq_masked", 32'(irq), 32'h0);
    bus_read("stat_b5", A_STAT, 32'h20);
    bus_write(A_STAT, 32'h04);
    bus_read("stat_w1c_other", A_STAT, 32'h20);
    bus_write(A_STAT, 32'h20);
    bus_read("stat_b5_clr", A_STAT, 32'h00);

    // Collision: W1C lands on the same edge that detects a new change
    gpio_in[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_write(A_STAT, 32'h04);
    bus_read("stat_collide", A_STAT, 32'h04);
    check_val("irq_collide", 32'(irq), 32'h1);
    bus_write(A_STAT, 32'h04);
    bus_read("stat_collide_clr", A_STAT, 32'h00);

    // Asynchronous reset mid-cycle with outputs driven and irq pending
    bus_write(A_OUT, 32'hFF);
    bus_write(A_DIR, 32'hFF);
    bus_write(A_IEN, 32'hFF);
    gpio_in[0] = 1'b1;
    cycles(3);
    check_val("pre_rst_irq", 32'(irq), 32'h1);
    check_val("pre_rst_oe", 32'(gpio_oe), 32'hFF);
    address = A_OUT;
    cycles(1);
    check_val("pre_rst_rd", data_out, 32'hFF);
    data_in = 32'h00;
    write   = 1'b1;
    #2;
    rst     = 1'b1;
    gpio_in = '1;
    #1;
    check_val("async_out", 32'(gpio_out), 32'(RST_OUT));
    check_val("async_oe",  32'(gpio_oe),  32'h0);
    check_val("async_irq", 32'(irq),      32'h0);
    check_val("async_rd",  data_out,      32'h0);
    write   = 1'b0;
    address = A_IDLE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Arming: pins high through reset release give no STAT
    bus_read("in_e1", A_IN, 32'h00);
    bus_read("in_e2", A_IN, 32'h00);
    bus_read("in_e3", A_IN, 32'hFF);
    for (int i = 0; i < 10; i++) begin
      bus_read($sformatf("arm_stat%0d", i), A_STAT, 32'h00);
    end
    bus_write(A_IEN, 32'hFF);
    check_val("arm_irq", 32'(irq), 32'h0);

    // Decode: unaligned and out-of-window accesses
    bus_write(BASE + 10'h01, 32'hAA);
    bus_write(BASE + 10'h20, 32'hAA);
    check_val("dec_out", 32'(gpio_out), 32'(RST_OUT));
    bus_read("dec_unal", BASE + 10'h01, 32'h0);
    bus_read("dec_high", BASE + 10'h20, 32'h0);
    bus_read("dec_low",  BASE - 10'h04, 32'h0);
    bus_read("dec_rdout", A_OUT, 32'(RST_OUT));

    // Upper data_in bits are dropped, upper data_out bits read 0
    bus_write(A_OUT, 32'hFFFF_FF12);
    check_val("wide_out", 32'(gpio_out), 32'h12);
    bus_read("wide_rd", A_OUT, 32'h0000_0012);

    check_val("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
